icache_nway: RTL
================

# icache_nway

Parametrised N-way set-associative, read-only instruction cache between the IF stage and the AXI read bridge. It generalises the fixed two-way, 128-set instruction cache in four ways: configurable way count, set count and line size; tree-PLRU replacement; invalid-first victim choice; and a CACHE-instruction invalidate port. It returns the addressed word plus every following word of the line for fetch-buffer fill. Uncached fetches bypass the arrays as single-word reads.

## Interface
- WAYS, 2, associativity; legal values 1, 2, 4.
- INDEX_W, 7, set index width; the cache has 2^INDEX_W sets.
- OFFSET_W, 5, byte offset width; line = 2^OFFSET_W bytes, LINE_W = 8·2^OFFSET_W bits, NWORDS = LINE_W/32.
- TAG_W, 32-INDEX_W-OFFSET_W, derived; not overridable.
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- valid  in  1  fetch request
- uncache  in  1  fetch is uncached
- tag / index / offset  in  TAG_W / INDEX_W / OFFSET_W  fetch physical address fields
- addr_ok  out  1  request accepted this cycle
- data_ok  out  1  rdata/rnum valid this cycle
- rdata  out  LINE_W  words from offset to end of line, word 0 at bits [31:0], zero-filled above
- rnum  out  OFFSET_W  number of valid words in rdata
- inv_valid  in  1  invalidate request
- inv_mode  in  1  0 = index-invalidate (all ways of set), 1 = hit-invalidate (matching tag only)
- inv_tag / inv_index  in  TAG_W / INDEX_W  invalidate target
- inv_ok  out  1  one-cycle pulse when invalidate completes
- rd_req  out  1  AXI read request
- rd_type  out  1  1 = full line, 0 = single word
- rd_addr  out  32  read address; line-aligned when rd_type=1
- rd_rdy  in  1  bridge accepts rd_req
- ret_valid  in  1  return data valid, one beat
- ret_data  in  LINE_W  returned line; word at [31:0] for uncached reads

## Operation
- Storage per way:
  - Tag and data arrays are single-port synchronous RAMs with 1-cycle read latency.
  - Valid bits and PLRU bits (WAYS-1 per set) are flops.
- States: IDLE, LOOKUP, MISS, REFILL, UREQ, URESP, INV.
- addr_ok = valid & !inv_valid & (IDLE | (LOOKUP & hit)).
  - Acceptance latches tag/index/offset/uncache into the request buffer.
  - A cached accept also reads all ways at the new index.
- IDLE:
  - inv_valid has priority: latch the request, read tags, go to INV.
  - Otherwise an accepted cached request goes to LOOKUP; an accepted uncached request goes to UREQ.
- LOOKUP:
  - hit = any way with V set and stored tag == buffered tag.
  - On hit: data_ok=1; rdata = hit line >> (32·word offset); rnum = NWORDS - word offset; update PLRU. Next state is LOOKUP, UREQ or IDLE depending on the new accept.
  - On miss: pick the victim (lowest-numbered invalid way, else the PLRU victim), register it, go to MISS.
- MISS: rd_req=1, rd_type=1, rd_addr={tag,index,0}. Go to REFILL on rd_rdy.
- REFILL, on ret_valid:
  - Write tag and line into the victim way; set V; update PLRU to mark the victim MRU.
  - data_ok=1 with rdata/rnum derived from ret_data.
  - Go to IDLE.
- UREQ: rd_req=1, rd_type=0, rd_addr = full buffered address. Go to URESP on rd_rdy.
- URESP, on ret_valid: data_ok=1, rdata={0, ret_data[31:0]}, rnum=1, go to IDLE. Arrays and PLRU are untouched.
- INV:
  - Mode 0 clears V of all ways in the set.
  - Mode 1 clears V only of the matching way.
  - inv_ok=1 this cycle; go to IDLE. PLRU is unchanged.
- PLRU tree:
  - A touch sets the path bits to point away from the touched way.
  - The victim is found by following the bits.
  - WAYS=1: victim is always way 0 and no PLRU bits exist.

## Timing
- Reset values: state=IDLE; all V=0; all PLRU bits=0; data_ok=rd_req=inv_ok=0. addr_ok is combinational on valid/inv_valid.
- Hit: accept at T, data_ok at T+1. Back-to-back hits sustain one per cycle.
- Miss: accept T, LOOKUP miss T+1, rd_req from T+2. data_ok arrives in the same cycle as ret_valid; next accept is possible the cycle after.
- Uncached: rd_req the cycle after accept.
- Invalidate: accepted at T, inv_ok at T+1. A fetch presented with inv_valid waits.
- rd_req stays asserted and rd_addr stays stable until rd_rdy.
- ret_valid is ignored in IDLE, LOOKUP, MISS, UREQ and INV.
- Reset mid-MISS/REFILL/URESP: return to IDLE, clear all V; a late ret_valid is dropped.

## Test plan
- WAYS=4: miss at 0x0000_1008 -> rd_req with rd_addr=0x0000_1000, rd_type=1. Return a line with word k = k. Expect data_ok, rdata[31:0]=2, rnum=6. Refetch -> hit at T+1, same data.
- Five tags to one set (WAYS=4) -> ways 0-3 fill invalid-first. Rehit tag 0, then a fifth miss -> the PLRU victim is not the tag-0 way; confirm via hit/miss on the subsequent refetch of all tags.
- Uncached fetch at 0x1FC0_0004 -> rd_type=0, rd_addr=0x1FC0_0004. On return: rnum=1, rdata[31:0]=ret_data[31:0]. A refetch still misses the cache.
- Hit-invalidate of a cached line -> inv_ok at T+1, next fetch misses. Index-invalidate clears all ways of the set.
- Back-to-back hits across 3 different sets -> data_ok every cycle. Hold rd_rdy=0 for 5 cycles on a miss -> rd_req and rd_addr stay stable.
- Assert resetn=0 during REFILL, then deliver ret_valid -> no data_ok; previously cached lines miss.

Source files
------------

// File: rtl/icache_nway_if.sv
// icache_nway_if: bundle of the fetch, invalidate and refill signals around
// the instruction cache.
//   slave  modport - the cache: takes fetch/invalidate requests and return data,
//                    drives accept/data handshakes and the read request.
//   master modport - the IF stage plus AXI read bridge (the cache's environment).
// INDEX_W/OFFSET_W must match the cache instance; TAG_W and LINE_W are derived.
interface icache_nway_if #(
    parameter int INDEX_W  = 7,
    parameter int OFFSET_W = 5
);
    localparam int TAG_W  = 32 - INDEX_W - OFFSET_W;
    localparam int LINE_W = 8 * (1 << OFFSET_W);

    // fetch request / response
    logic                valid;
    logic                uncache;
    logic [TAG_W-1:0]    tag;
    logic [INDEX_W-1:0]  index;
    logic [OFFSET_W-1:0] offset;
    logic                addr_ok;
    logic                data_ok;
    logic [LINE_W-1:0]   rdata;
    logic [OFFSET_W-1:0] rnum;
    // CACHE-instruction invalidate
    logic                inv_valid;
    logic                inv_mode;
    logic [TAG_W-1:0]    inv_tag;
    logic [INDEX_W-1:0]  inv_index;
    logic                inv_ok;
    // read bridge
    logic                rd_req;
    logic                rd_type;
    logic [31:0]         rd_addr;
    logic                rd_rdy;
    logic                ret_valid;
    logic [LINE_W-1:0]   ret_data;

    modport slave (
        input  valid, uncache, tag, index, offset,
        input  inv_valid, inv_mode, inv_tag, inv_index,
        input  rd_rdy, ret_valid, ret_data,
        output addr_ok, data_ok, rdata, rnum, inv_ok,
        output rd_req, rd_type, rd_addr
    );

    modport master (
        output valid, uncache, tag, index, offset,
        output inv_valid, inv_mode, inv_tag, inv_index,
        output rd_rdy, ret_valid, ret_data,
        input  addr_ok, data_ok, rdata, rnum, inv_ok,
        input  rd_req, rd_type, rd_addr
    );
endinterface

// File: rtl/icache_nway.sv
// icache_nway: N-way (1/2/4) set-associative read-only instruction cache with
// tree-PLRU replacement, invalid-first victim choice, index/hit invalidate and
// uncached single-word bypass. A hit returns the addressed word and every later
// word of the line (word 0 at rdata[31:0]), with rnum giving the word count.
// Ports:
//   clk     - clock
//   resetn  - synchronous active-low reset (clears state, valid and PLRU bits)
//   bus     - icache_nway_if.slave: fetch, invalidate and read-bridge signals
module icache_nway #(
    parameter int WAYS     = 2,
    parameter int INDEX_W  = 7,
    parameter int OFFSET_W = 5
) (
    input  logic         clk,
    input  logic         resetn,
    icache_nway_if.slave bus
);
    localparam int TAG_W  = 32 - INDEX_W - OFFSET_W;
    localparam int LINE_W = 8 * (1 << OFFSET_W);
    localparam int NWORDS = LINE_W / 32;
    localparam int SETS   = 1 << INDEX_W;
    localparam int LOG_W  = $clog2(WAYS);
    localparam int WAY_W  = (WAYS > 1) ? LOG_W : 1;
    localparam int PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;
    localparam int WO_W   = OFFSET_W - 2;

    typedef enum logic [2:0] {IDLE, LOOKUP, MISS, REFILL, UREQ, URESP, INV} state_t;

    // PLRU bits form a heap-ordered tree: node n has children 2n+1 / 2n+2,
    // bit value selects the child holding the next victim.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] bits);
        int n = 0;
        for (int l = 0; l < LOG_W; l++) n = 2 * n + 1 + int'(bits[n]);
        return WAY_W'(n - (WAYS - 1));
    endfunction

    function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] bits,
                                                     input logic [WAY_W-1:0]  way);
        logic [PLRU_W-1:0] r = bits;
        int n = 0;
        logic dir;
        for (int l = 0; l < LOG_W; l++) begin
            dir  = way[LOG_W-1-l];
            r[n] = ~dir;               // point away from the touched way
            n    = 2 * n + 1 + int'(dir);
        end
        return r;
    endfunction

    state_t state_q, state_d;

    // request buffer (also holds the invalidate target while in INV)
    logic [TAG_W-1:0]    tag_q;
    logic [INDEX_W-1:0]  index_q;
    logic [OFFSET_W-1:0] offset_q;
    logic                inv_mode_q;
    logic [WAY_W-1:0]    victim_q;

    logic [SETS-1:0][WAYS-1:0]   v_q;
    logic [SETS-1:0][PLRU_W-1:0] plru_q;

    logic [TAG_W-1:0]  tag_ram  [WAYS][SETS];
    logic [LINE_W-1:0] data_ram [WAYS][SETS];
    logic [TAG_W-1:0]  tag_rd_q [WAYS];
    logic [LINE_W-1:0] data_rd_q[WAYS];

    logic [WAYS-1:0]    hit_way;
    logic               hit;
    logic [LINE_W-1:0]  hit_line;
    logic [WAY_W-1:0]   hit_idx;
    logic [WAY_W-1:0]   fill_way;
    logic               accept;
    logic               inv_acc;
    logic               refill_we;
    logic               ram_re;
    logic [INDEX_W-1:0] ram_index;
    logic [WO_W-1:0]    wo;

    assign wo = offset_q[OFFSET_W-1:2];

    // Tag compare against the buffered tag; in INV the buffer holds inv_tag,
    // so hit_way doubles as the hit-invalidate match vector.
    always_comb begin
        hit_way  = '0;
        hit_line = '0;
        hit_idx  = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_way[w] = v_q[index_q][w] && (tag_rd_q[w] == tag_q);
            if (hit_way[w]) begin
                hit_line = hit_line | data_rd_q[w];
                hit_idx  = WAY_W'(w);
            end
        end
        hit = |hit_way;
        // lowest-numbered invalid way wins over the PLRU choice
        fill_way = plru_victim(plru_q[index_q]);
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!v_q[index_q][w]) fill_way = WAY_W'(w);
        end
    end

    always_comb begin
        state_d     = state_q;
        bus.data_ok = 1'b0;
        bus.rdata   = '0;
        bus.rnum    = '0;
        bus.inv_ok  = 1'b0;
        bus.rd_req  = 1'b0;
        bus.rd_type = 1'b0;
        bus.rd_addr = '0;
        inv_acc     = 1'b0;
        refill_we   = 1'b0;
        accept      = bus.valid && !bus.inv_valid &&
                      (state_q == IDLE || (state_q == LOOKUP && hit));
        bus.addr_ok = accept;
        case (state_q)
            IDLE: begin
                if (bus.inv_valid) begin
                    inv_acc = 1'b1;
                    state_d = INV;
                end else if (accept) begin
                    state_d = bus.uncache ? UREQ : LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    bus.data_ok = 1'b1;
                    bus.rdata   = hit_line >> {wo, 5'd0};
                    bus.rnum    = OFFSET_W'(NWORDS) - OFFSET_W'(wo);
                    state_d     = accept ? (bus.uncache ? UREQ : LOOKUP) : IDLE;
                end else begin
                    state_d = MISS;
                end
            end
            MISS: begin
                bus.rd_req  = 1'b1;
                bus.rd_type = 1'b1;
                bus.rd_addr = {tag_q, index_q, {OFFSET_W{1'b0}}};
                if (bus.rd_rdy) state_d = REFILL;
            end
            REFILL: begin
                if (bus.ret_valid) begin
                    refill_we   = 1'b1;
                    bus.data_ok = 1'b1;
                    bus.rdata   = bus.ret_data >> {wo, 5'd0};
                    bus.rnum    = OFFSET_W'(NWORDS) - OFFSET_W'(wo);
                    state_d     = IDLE;
                end
            end
            UREQ: begin
                bus.rd_req  = 1'b1;
                bus.rd_addr = {tag_q, index_q, offset_q};
                if (bus.rd_rdy) state_d = URESP;
            end
            URESP: begin
                if (bus.ret_valid) begin
                    bus.data_ok = 1'b1;
                    bus.rdata   = LINE_W'(bus.ret_data[31:0]);
                    bus.rnum    = OFFSET_W'(1);
                    state_d     = IDLE;
                end
            end
            INV: begin
                bus.inv_ok = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
        ram_re    = (accept && !bus.uncache) || inv_acc;
        ram_index = inv_acc ? bus.inv_index : bus.index;
    end

    // Control state: FSM, valid bits, PLRU
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            v_q     <= '0;
            plru_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == LOOKUP && hit)
                plru_q[index_q] <= plru_touch(plru_q[index_q], hit_idx);
            if (refill_we) begin
                v_q[index_q][victim_q] <= 1'b1;
                plru_q[index_q]        <= plru_touch(plru_q[index_q], victim_q);
            end
            if (state_q == INV)
                v_q[index_q] <= inv_mode_q ? (v_q[index_q] & ~hit_way) : '0;
        end
    end

    // Request buffer and registered victim
    always_ff @(posedge clk) begin
        if (inv_acc) begin
            tag_q      <= bus.inv_tag;
            index_q    <= bus.inv_index;
            inv_mode_q <= bus.inv_mode;
        end else if (accept) begin
            tag_q    <= bus.tag;
            index_q  <= bus.index;
            offset_q <= bus.offset;
        end
        if (state_q == LOOKUP && !hit) victim_q <= fill_way;
    end

    // Single-port tag/data RAMs, one-cycle read latency; refill write has priority
    always_ff @(posedge clk) begin
        for (int w = 0; w < WAYS; w++) begin
            if (refill_we && victim_q == WAY_W'(w)) begin
                tag_ram[w][index_q]  <= tag_q;
                data_ram[w][index_q] <= bus.ret_data;
            end else if (ram_re) begin
                tag_rd_q[w]  <= tag_ram[w][ram_index];
                data_rd_q[w] <= data_ram[w][ram_index];
            end
        end
    end
endmodule
